adv_button_cond: RTL and testbench
==================================

// Module: adv_button_cond
// PURPOSE
//  Conditions raw Minadv/Hrsadv pushbuttons before they reach the alarm-clock core (struct_diag).
//  Each button passes through a 2-FF synchronizer and a debounce FSM. A clean press produces one single-cycle Adv strobe.
//  Holding the button produces auto-repeat strobes, so the core advances exactly once per strobe.
// PARAMETERS
//  N_BTN         2   number of independent buttons (bit 0 = Minadv, bit 1 = Hrsadv)
//  DEB_CYCLES    4   consecutive stable synced samples needed to accept a press/release (>=1)
//  HOLD_CYCLES   16  cycles in HELD after first strobe before auto-repeat starts (>=1)
//  REPEAT_CYCLES 4   strobe interval in REPEAT (>=2)
//  ACCEL_AFTER   8   repeats before interval halves (used only with REPEAT_ACCEL_EN)
// PORTS
//  Clk       in   1      system clock (Pulse in top-level bench)
//  Reset_n   in   1      asynchronous active-low reset
//  Btn_raw   in   N_BTN  raw, asynchronous, bouncy button levels, active-high
//  Set_mode  in   1      Timeset|Alarmset from core; strobes suppressed when 0
//  Adv       out  N_BTN  registered one-cycle advance strobe per button
//  Btn_held  out  N_BTN  registered debounced level (1 in HELD/REPEAT/DEB_RELEASE)
// BEHAVIOUR
//  - Reset (async assert, sync deassert via Reset_n sampling): sync FFs=0, FSM=IDLE, counters=0, Adv=0, Btn_held=0.
//  - Per button: s = sync2(sync1(Btn_raw[i])); all decisions use s only. Buttons are fully independent.
//  - States: IDLE, DEB_PRESS, HELD, REPEAT, DEB_RELEASE; cnt width $clog2(max(DEB,HOLD,REPEAT)+1).
//  - IDLE: s=1 -> DEB_PRESS, cnt=0.
//  - DEB_PRESS: s=0 -> IDLE (bounce rejected, no strobe).
//    - s=1 and cnt==DEB_CYCLES-1 -> HELD, cnt=0, fire.
//    - else cnt++.
//  - HELD: s=0 -> DEB_RELEASE, cnt=0.
//    - cnt==HOLD_CYCLES-1 -> REPEAT, cnt=0, fire.
//    - else cnt++.
//  - REPEAT: s=0 -> DEB_RELEASE, cnt=0.
//    - cnt==interval-1 -> cnt=0, fire.
//    - else cnt++.
//  - DEB_RELEASE: s=1 -> HELD, cnt=0 (no strobe; hold timer restarts).
//    - cnt==DEB_CYCLES-1 -> IDLE.
//    - else cnt++.
//  - fire: Adv[i]<=Set_mode on that edge; Adv is 0 on every other edge. Adv is never high two consecutive cycles.
//  - Latency: first edge sampling Btn_raw=1 is E0. Adv is high for the cycle after edge E0+DEB_CYCLES+2 (default E0+6).
//    - 2nd strobe follows HOLD_CYCLES cycles later; each later strobe follows REPEAT_CYCLES cycles later.
//  - Set_mode=0 gates Adv only; FSM and Btn_held behave normally. Set_mode rising mid-hold: next scheduled fire strobes.
//  - Reset_n low mid-operation: immediate return to reset values; a button still held after release re-debounces from IDLE.
//  - Both buttons pressed together: both strobe on the same cycle; the core resolves priority.
// CONFIGURATION
//  `REPEAT_ACCEL_EN defined: a per-button repeat counter saturates at ACCEL_AFTER.
//    - Once saturated, interval = REPEAT_CYCLES/2 (floor, min 1). Counter clears on leaving REPEAT.
//  `REPEAT_ACCEL_EN undefined: interval = REPEAT_CYCLES always; no repeat counter is synthesized.
// TESTING (defaults, Clk period 2ns)
//  1. Reset_n=0 for 3 cycles with Btn_raw=2'b11 -> Adv=0, Btn_held=0 throughout; after release, first Adv at E0+6.
//  2. Btn_raw[0] toggles 1,0,1,0 each cycle then stays 0 -> no Adv, Btn_held[0]=0, FSM back in IDLE.
//  3. Btn_raw[0]=1 held 40 cycles, Set_mode=1 -> Adv[0] strobes at E0+6, +16, then every 4 cycles (E0+26, +30 ...).
//     - Strobes stop within DEB_CYCLES+2 cycles of release.
//  4. Same hold with Set_mode=0 -> Adv=0 always; Btn_held[0]=1 from E0+6 until release debounced.
//  5. Hold 20 cycles, 2-cycle low glitch, hold again -> no extra strobe at glitch; next strobe 16 cycles after re-entry to HELD.
//  6. REPEAT_ACCEL_EN, 80-cycle hold -> after 8 repeat strobes the spacing drops from 4 to 2 cycles; both buttons together strobe in lockstep.

Source files
------------

// File: rtl/adv_button_cond_if.sv
// Button-conditioner bus: raw button levels and set mode toward the conditioner,
// advance strobes and debounced held levels back toward the alarm-clock core.
`timescale 1ns/1ps
interface adv_button_cond_if #(
  parameter int N_BTN = 2
);
  logic [N_BTN-1:0] btn_raw;
  logic             set_mode;
  logic [N_BTN-1:0] adv;
  logic [N_BTN-1:0] btn_held;

  modport master (output btn_raw, output set_mode, input adv, input btn_held);
  modport slave  (input btn_raw, input set_mode, output adv, output btn_held);
endinterface

// File: rtl/adv_button_cond.sv
// Per-button 2-FF synchronizer, debounce FSM and auto-repeat strobe generator.
// Optional macro REPEAT_ACCEL_EN halves the repeat interval after ACCEL_AFTER repeats.
`timescale 1ns/1ps
module adv_button_cond #(
  parameter int N_BTN         = 2,
  parameter int DEB_CYCLES    = 4,
  parameter int HOLD_CYCLES   = 16,
  parameter int REPEAT_CYCLES = 4,
  parameter int ACCEL_AFTER   = 8
) (
  input logic              clk,
  input logic              rst_n,
  adv_button_cond_if.slave bus
);

  localparam int CNT_MAX = (DEB_CYCLES > HOLD_CYCLES)
                         ? ((DEB_CYCLES > REPEAT_CYCLES) ? DEB_CYCLES : REPEAT_CYCLES)
                         : ((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DEB_PRESS, S_HELD, S_REPEAT, S_DEB_RELEASE
  } state_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t DEB_LAST  = cnt_t'(DEB_CYCLES - 1);
  localparam cnt_t HOLD_LAST = cnt_t'(HOLD_CYCLES - 1);

  if (DEB_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 2 || ACCEL_AFTER < 1) begin : g_param_check
    $error("adv_button_cond: parameter out of range");
  end

  logic [N_BTN-1:0] sync1, sync2;
  logic [N_BTN-1:0] adv_d, held_d, adv_q, held_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.btn_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    state_t state, state_nxt;
    cnt_t   cnt, cnt_nxt, rep_last;
    logic   s, fire, adv_nxt, held_nxt;

    assign s = sync2[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      fire      = 1'b0;
      unique case (state)
        S_IDLE: begin
          if (s) begin
            state_nxt = S_DEB_PRESS;
            cnt_nxt   = '0;
          end
        end
        S_DEB_PRESS: begin
          if (!s) begin
            state_nxt = S_IDLE;
          end else if (cnt == DEB_LAST) begin
            state_nxt = S_HELD;
            cnt_nxt   = '0;
            fire      = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        S_HELD: begin
          if (!s) begin
            state_nxt = S_DEB_RELEASE;
            cnt_nxt   = '0;
          end else if (cnt == HOLD_LAST) begin
            state_nxt = S_REPEAT;
            cnt_nxt   = '0;
            fire      = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        S_REPEAT: begin
          if (!s) begin
            state_nxt = S_DEB_RELEASE;
            cnt_nxt   = '0;
          end else if (cnt == rep_last) begin
            cnt_nxt = '0;
            fire    = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        S_DEB_RELEASE: begin
          // A renewed press restarts the hold timer rather than strobing again.
          if (s) begin
            state_nxt = S_HELD;
            cnt_nxt   = '0;
          end else if (cnt == DEB_LAST) begin
            state_nxt = S_IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    always_comb begin
      adv_nxt  = fire & bus.set_mode;
      held_nxt = (state_nxt == S_HELD) || (state_nxt == S_REPEAT) ||
                 (state_nxt == S_DEB_RELEASE);
    end

    assign adv_d[i]  = adv_nxt;
    assign held_d[i] = held_nxt;

`ifdef REPEAT_ACCEL_EN
    localparam int   REP_W     = $clog2(ACCEL_AFTER + 1);
    localparam int   FAST      = (REPEAT_CYCLES / 2 < 1) ? 1 : REPEAT_CYCLES / 2;
    localparam logic [REP_W-1:0] REP_SAT = REP_W'(ACCEL_AFTER);
    logic [REP_W-1:0] rep_cnt, rep_cnt_nxt;

    always_comb begin
      rep_cnt_nxt = rep_cnt;
      if (state == S_REPEAT) begin
        if (state_nxt != S_REPEAT)
          rep_cnt_nxt = '0;
        else if (fire && rep_cnt != REP_SAT)
          rep_cnt_nxt = rep_cnt + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rep_cnt <= '0;
      else        rep_cnt <= rep_cnt_nxt;
    end

    assign rep_last = (rep_cnt == REP_SAT) ? cnt_t'(FAST - 1) : cnt_t'(REPEAT_CYCLES - 1);
`else
    assign rep_last = cnt_t'(REPEAT_CYCLES - 1);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adv_q  <= '0;
      held_q <= '0;
    end else begin
      adv_q  <= adv_d;
      held_q <= held_d;
    end
  end

  assign bus.adv      = adv_q;
  assign bus.btn_held = held_q;

endmodule

// File: tb/tb_adv_button_cond.sv
// Self-checking bench for adv_button_cond: press table, corner-case sequences and
// randomized button traffic against a run-length reference model.
`timescale 1ns/1ps
module tb_adv_button_cond;

  localparam int N_BTN = 2;
  localparam int DEB   = 4;
  localparam int HOLD  = 16;
  localparam int REP   = 4;
  localparam int ACCEL = 8;
`ifdef REPEAT_ACCEL_EN
  localparam bit ACCEL_ON = 1'b1;
`else
  localparam bit ACCEL_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #1 clk = ~clk;

  adv_button_cond_if #(.N_BTN(N_BTN)) bus ();

  adv_button_cond #(
    .N_BTN(N_BTN), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .ACCEL_AFTER(ACCEL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a press is accepted after DEB+1 consecutive high synced samples,
  // a release after DEB+1 consecutive low ones; strobes are spaced by elapsed-sample ages.
  int run_m [N_BTN];
  int low_m [N_BTN];
  int age_m [N_BTN];
  int reps_m[N_BTN];
  bit held_m[N_BTN];
  bit rptg_m[N_BTN];
  logic [N_BTN-1:0] pipe0 = '0, pipe1 = '0, exp_adv = '0, exp_held = '0;

  function automatic int repeat_period(input int reps);
    if (ACCEL_ON && reps >= ACCEL) return (REP / 2 < 1) ? 1 : REP / 2;
    return REP;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe0 = '0; pipe1 = '0; exp_adv = '0; exp_held = '0;
      for (int i = 0; i < N_BTN; i++) begin
        run_m[i] = 0; low_m[i] = 0; age_m[i] = 0; reps_m[i] = 0;
        held_m[i] = 1'b0; rptg_m[i] = 1'b0;
      end
    end else begin
      logic [N_BTN-1:0] s;
      s = pipe1;
      pipe1 = pipe0;
      pipe0 = bus.btn_raw;
      exp_adv = '0;
      for (int i = 0; i < N_BTN; i++) begin
        bit fire;
        fire = 1'b0;
        if (!held_m[i]) begin
          run_m[i] = s[i] ? run_m[i] + 1 : 0;
          if (run_m[i] == DEB + 1) begin
            held_m[i] = 1'b1; fire = 1'b1;
            age_m[i] = 0; rptg_m[i] = 1'b0; low_m[i] = 0; reps_m[i] = 0;
          end
        end else if (low_m[i] > 0) begin
          if (s[i]) begin
            low_m[i] = 0; age_m[i] = 0; rptg_m[i] = 1'b0;
          end else begin
            low_m[i]++;
            if (low_m[i] == DEB + 1) begin
              held_m[i] = 1'b0; run_m[i] = 0;
            end
          end
        end else if (!s[i]) begin
          low_m[i] = 1; reps_m[i] = 0;
        end else begin
          age_m[i]++;
          if (age_m[i] == (rptg_m[i] ? repeat_period(reps_m[i]) : HOLD)) begin
            fire = 1'b1;
            age_m[i] = 0;
            if (rptg_m[i] && reps_m[i] < ACCEL) reps_m[i]++;
            rptg_m[i] = 1'b1;
          end
        end
        if (fire) exp_adv[i] = bus.set_mode;
        exp_held[i] = held_m[i];
      end
    end
  end

  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      check("model_adv", int'(bus.adv), int'(exp_adv));
      check("model_held", int'(bus.btn_held), int'(exp_held));
    end
  end

  typedef struct {
    int btn;
    int len;
    bit mode;
    int n_strobes;
    int first;
    int held_cycles;
  } press_t;

  press_t tbl [10];

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_press(input press_t p);
    int first, n, hc, other, dbl;
    logic prev;
    first = -1; n = 0; hc = 0; other = 0; dbl = 0; prev = 1'b0;
    bus.btn_raw[p.btn] = 1'b1;
    bus.set_mode = p.mode;
    for (int k = 0; k < p.len + DEB + 12; k++) begin
      @(negedge clk);
      if (bus.adv[p.btn]) begin
        n++;
        if (first < 0) first = k;
        if (prev) dbl++;
      end
      prev = bus.adv[p.btn];
      if (bus.btn_held[p.btn]) hc++;
      if (bus.adv[1 - p.btn]) other++;
      if (k == p.len - 1) bus.btn_raw[p.btn] = 1'b0;
    end
    check($sformatf("tbl_strobes_len%0d_m%0d", p.len, p.mode), n, p.n_strobes);
    check($sformatf("tbl_first_len%0d_m%0d", p.len, p.mode), first, p.first);
    check($sformatf("tbl_held_len%0d_m%0d", p.len, p.mode), hc, p.held_cycles);
    check("tbl_no_double_strobe", dbl, 0);
    check("tbl_other_btn_quiet", other, 0);
    bus.set_mode = 1'b1;
    idle(3);
  endtask

  initial begin
    int first0, first1, cnt_adv, cnt_held, mism;
    int q[$];
    int rem[N_BTN];
    int exp_n, exp_gap;

    tbl[0] = '{0,  3, 1'b1, 0, -1,  0};
    tbl[1] = '{0,  4, 1'b1, 0, -1,  0};
    tbl[2] = '{0,  5, 1'b1, 1,  6,  5};
    tbl[3] = '{1,  5, 1'b1, 1,  6,  5};
    tbl[4] = '{0, 20, 1'b1, 1,  6, 20};
    tbl[5] = '{0, 21, 1'b1, 2,  6, 21};
    tbl[6] = '{1, 24, 1'b1, 2,  6, 24};
    tbl[7] = '{1, 25, 1'b1, 3,  6, 25};
    tbl[8] = '{0, 40, 1'b1, 6,  6, 40};
    tbl[9] = '{0, 40, 1'b0, 0, -1, 40};

    // Reset held with both buttons pressed.
    rst_n = 1'b0;
    bus.btn_raw = 2'b11;
    bus.set_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset_adv", int'(bus.adv), 0);
      check("reset_held", int'(bus.btn_held), 0);
    end
    mon_en = 1'b1;
    #0.5 rst_n = 1'b1;
    first0 = -1; first1 = -1; mism = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.adv[0] && first0 < 0) first0 = k;
      if (bus.adv[1] && first1 < 0) first1 = k;
    end
    check("reset_first_adv0", first0, 6);
    check("reset_first_adv1", first1, 6);
    bus.btn_raw = '0;
    idle(20);

    // Bounce pattern never long enough to be accepted.
    cnt_adv = 0; cnt_held = 0;
    bus.btn_raw[0] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      bus.btn_raw[0] = (k < 3) ? ~bus.btn_raw[0] : 1'b0;
      if (bus.adv[0]) cnt_adv++;
      if (bus.btn_held[0]) cnt_held++;
    end
    check("bounce_adv", cnt_adv, 0);
    check("bounce_held", cnt_held, 0);
    idle(3);

    foreach (tbl[i]) run_press(tbl[i]);

    // 20-cycle hold, 2-cycle glitch, 20-cycle hold: hold timer restarts at re-entry.
    q.delete();
    bus.btn_raw[0] = 1'b1;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (bus.adv[0]) q.push_back(k);
      bus.btn_raw[0] = ((k + 1) < 20) || ((k + 1) >= 22 && (k + 1) < 42);
    end
    check("glitch_strobe_count", q.size(), 2);
    if (q.size() >= 2) begin
      check("glitch_first", q[0], 6);
      check("glitch_second", q[1], 40);
    end
    idle(3);

    // Both buttons held 80 cycles: lockstep strobes, repeat spacing.
    q.delete(); mism = 0;
    bus.btn_raw = 2'b11;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.adv[0]) q.push_back(k);
      if (bus.adv[0] != bus.adv[1]) mism++;
      if (k == 79) bus.btn_raw = 2'b00;
    end
    exp_n   = ACCEL_ON ? 23 : 16;
    exp_gap = ACCEL_ON ? 2 : 4;
    check("long_lockstep", mism, 0);
    check("long_strobe_count", q.size(), exp_n);
    if (q.size() > 10) begin
      check("long_gap_before_accel", q[9] - q[8], 4);
      check("long_gap_after_accel", q[10] - q[9], exp_gap);
    end
    idle(3);

    // Reset while held; button still down afterwards re-debounces from idle.
    bus.btn_raw = 2'b11;
    idle(13);
    #0.5 rst_n = 1'b0;
    #0.2;
    check("midreset_adv", int'(bus.adv), 0);
    check("midreset_held", int'(bus.btn_held), 0);
    @(negedge clk);
    @(negedge clk);
    #0.5 rst_n = 1'b1;
    first0 = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.adv[0] && first0 < 0) first0 = k;
    end
    check("midreset_first_adv", first0, 6);
    bus.btn_raw = '0;
    idle(10);

    // Randomized traffic: mixture of bounces and long holds, set_mode toggling.
    for (int i = 0; i < N_BTN; i++) rem[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N_BTN; i++) begin
        if (rem[i] == 0) begin
          bus.btn_raw[i] = ~bus.btn_raw[i];
          rem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 60);
        end else begin
          rem[i]--;
        end
      end
      if ($urandom_range(0, 39) == 0) bus.set_mode = ~bus.set_mode;
    end
    bus.btn_raw = '0;
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
